// File: rtl/resp_pkg.sv
// Shared constants and types for the response dispatcher.
// Holds the default parameter values, the default-width ticket type and the
// "no ticket" value used by every counter and by the dispatcher itself.
package resp_pkg;

  localparam int DEF_NUM_CTR        = 5;
  localparam int DEF_TICKET_W       = 6;
  localparam int DEF_QUEUE_DEPTH    = 16;
  localparam int DEF_SERVICE_CYCLES = 8;

  // Width of the call_ctr output; covers up to 8 counters.
  localparam int CALL_W   = 3;
  // Width of the completed-service counter.
  localparam int SERVED_W = 16;
  // Maximum number of priority tickets tracked at once (RESP_PRIORITY_EN builds).
  localparam int VIP_DEPTH = 4;

  typedef logic [DEF_TICKET_W-1:0] ticket_t;

  // Ticket value meaning "nothing issued / nothing assigned".
  localparam ticket_t TICKET_NONE = '0;

endpackage

// File: rtl/resp_counter.sv
// One service counter: remembers the ticket it was last given, stays busy
// for SERVICE_CYCLES rising edges after a start, and raises done during the
// cycle whose closing edge ends the service so the dispatcher can count it
// at that same edge.
module resp_counter
  import resp_pkg::*;
#(
  parameter int TICKET_W       = DEF_TICKET_W,
  parameter int SERVICE_CYCLES = DEF_SERVICE_CYCLES
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TICKET_W-1:0] ticket_in,
  output logic                busy,
  output logic [TICKET_W-1:0] ticket,
  output logic                done
);

  localparam int TIMER_W = $clog2(SERVICE_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(SERVICE_CYCLES);

  logic [TIMER_W-1:0] timer;

  // The last busy edge is the one where the timer still reads 1.
  assign done = busy && (timer == TIMER_W'(1));

  // Load the timer on start, count it down while busy, drop busy at the end;
  // the held ticket is kept after the service so it stays visible when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      timer  <= '0;
      ticket <= TICKET_W'(TICKET_NONE);
    end else if (start) begin
      busy   <= 1'b1;
      timer  <= TIMER_LOAD;
      ticket <= ticket_in;
    end else if (busy) begin
      if (done) begin
        busy  <= 1'b0;
        timer <= '0;
      end else begin
        timer <= timer - TIMER_W'(1);
      end
    end
  end

endmodule

// File: rtl/resp_dispatch.sv
// Ticket dispenser and counter dispatcher.
// A button press issues the next ticket number; waiting tickets are handed,
// oldest first, to the lowest-numbered idle counter, one per clock edge.
// The queue is just two ticket counters (last issued, last served) plus a
// waiting count, so no ticket numbers are stored for ordinary service.
// Optional feature macro: RESP_PRIORITY_EN adds a vip input; vip tickets are
// served ahead of ordinary ones, and only their numbers are remembered.
module resp_dispatch
  import resp_pkg::*;
#(
  parameter int NUM_CTR        = DEF_NUM_CTR,
  parameter int TICKET_W       = DEF_TICKET_W,
  parameter int QUEUE_DEPTH    = DEF_QUEUE_DEPTH,
  parameter int SERVICE_CYCLES = DEF_SERVICE_CYCLES
)(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               button,
`ifdef RESP_PRIORITY_EN
  input  logic                               vip,
`endif
  output logic [TICKET_W-1:0]                last_ticket,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   waiting,
  output logic                               reject,
  output logic [NUM_CTR-1:0]                 ctr_busy,
  output logic [NUM_CTR*TICKET_W-1:0]        ctr_ticket,
  output logic                               call_valid,
  output logic [CALL_W-1:0]                  call_ctr,
  output logic [SERVED_W-1:0]                total_served
);

  localparam int WAIT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [WAIT_W-1:0] WAIT_FULL = WAIT_W'(QUEUE_DEPTH);
  localparam logic [TICKET_W-1:0] TICKET_MAX = '1;
  localparam int IDX_W = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1;

  // Ticket numbering runs 1 .. all-ones and then wraps back to 1, never 0.
  function automatic logic [TICKET_W-1:0] next_ticket(input logic [TICKET_W-1:0] t);
    return (t == TICKET_MAX) ? TICKET_W'(1) : t + TICKET_W'(1);
  endfunction

  // btn_low remembers that button was low at the previous edge; it clears in
  // reset so a button already held high when reset lifts is not a press.
  logic btn_low;
  logic req;
  logic accept;
  logic refuse;

  logic [TICKET_W-1:0] serve_ptr;
  logic                dispatch;
  logic                advance_serve;
  logic [TICKET_W-1:0] dispatch_ticket;

  logic             idle_found;
  logic [IDX_W-1:0] idle_idx;
  logic [NUM_CTR-1:0] start;
  logic [NUM_CTR-1:0] done;

  logic [WAIT_W-1:0]   waiting_next;
  logic [3:0]          done_count;
  logic [SERVED_W:0]   served_sum;
  logic [SERVED_W-1:0] served_next;

  assign req = button & btn_low;

  // Pick the lowest-indexed counter that is idle at the start of this cycle.
  always_comb begin
    idle_found = 1'b0;
    idle_idx   = '0;
    for (int i = NUM_CTR - 1; i >= 0; i--) begin
      if (!ctr_busy[i]) begin
        idle_found = 1'b1;
        idle_idx   = IDX_W'(i);
      end
    end
  end

`ifdef RESP_PRIORITY_EN
  // Priority tickets: vip_hist keeps vip ticket numbers in issue order. The
  // oldest vip_cnt - vip_pend entries have already been served but are kept
  // until the ordinary serve pointer steps over their numbers.
  logic [TICKET_W-1:0] vip_hist [VIP_DEPTH];
  logic [2:0]          vip_cnt;
  logic [2:0]          vip_pend;
  logic                vip_full;
  logic                vip_accept;
  logic                head_done;
  logic                cand_is_vip;
  logic                skip;
  logic                vip_disp;
  logic                norm_disp;
  logic                normal_avail;
  logic [TICKET_W-1:0] candidate;
  logic [1:0]          pend_idx;
  logic [1:0]          push_idx;

  // Decide between a vip dispatch, an ordinary dispatch and skipping an
  // already-served vip number in the ordinary sequence.
  always_comb begin
    vip_full     = (vip_cnt == 3'(VIP_DEPTH));
    refuse       = req && ((waiting == WAIT_FULL) || (vip && vip_full));
    accept       = req && !refuse;
    vip_accept   = accept && vip;
    candidate    = next_ticket(serve_ptr);
    head_done    = (vip_cnt != 3'd0) && (vip_cnt > vip_pend);
    cand_is_vip  = (vip_cnt != 3'd0) && (candidate == vip_hist[0]);
    skip         = cand_is_vip && head_done;
    normal_avail = int'(waiting) > int'(vip_pend);
    vip_disp     = (vip_pend != 3'd0) && idle_found;
    norm_disp    = !vip_disp && normal_avail && !cand_is_vip && idle_found;
    pend_idx     = 2'(vip_cnt - vip_pend);
    push_idx     = 2'(vip_cnt - 3'(skip));
    dispatch     = vip_disp || norm_disp;
    advance_serve = norm_disp || skip;
    dispatch_ticket = vip_disp ? vip_hist[pend_idx] : candidate;
  end

  // Maintain the vip number history and the count of vip tickets not yet served.
  always_ff @(posedge clk) begin
    if (rst) begin
      vip_cnt  <= 3'd0;
      vip_pend <= 3'd0;
      for (int i = 0; i < VIP_DEPTH; i++) begin
        vip_hist[i] <= TICKET_W'(TICKET_NONE);
      end
    end else begin
      if (skip) begin
        for (int i = 0; i < VIP_DEPTH - 1; i++) begin
          vip_hist[i] <= vip_hist[i+1];
        end
      end
      if (vip_accept) begin
        vip_hist[push_idx] <= next_ticket(last_ticket);
      end
      vip_cnt  <= vip_cnt + 3'(vip_accept) - 3'(skip);
      vip_pend <= vip_pend + 3'(vip_accept) - 3'(vip_disp);
    end
  end
`else
  // Strict FIFO: the oldest waiting ticket is always the one after serve_ptr.
  always_comb begin
    refuse          = req && (waiting == WAIT_FULL);
    accept          = req && !refuse;
    dispatch        = (waiting != '0) && idle_found;
    advance_serve   = dispatch;
    dispatch_ticket = next_ticket(serve_ptr);
  end
`endif

  // Waiting count: an issue and a dispatch in the same cycle cancel out.
  always_comb begin
    waiting_next = waiting;
    if (accept && !dispatch) begin
      waiting_next = waiting + WAIT_W'(1);
    end else if (!accept && dispatch) begin
      waiting_next = waiting - WAIT_W'(1);
    end
  end

  // Add every completion this cycle to the served total, saturating at all-ones.
  always_comb begin
    done_count = 4'd0;
    for (int i = 0; i < NUM_CTR; i++) begin
      done_count = done_count + 4'(done[i]);
    end
    served_sum  = {1'b0, total_served} + (SERVED_W+1)'(done_count);
    served_next = served_sum[SERVED_W] ? '1 : served_sum[SERVED_W-1:0];
  end

  // Issue/serve bookkeeping and the registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_low      <= 1'b0;
      last_ticket  <= TICKET_W'(TICKET_NONE);
      serve_ptr    <= TICKET_W'(TICKET_NONE);
      waiting      <= '0;
      reject       <= 1'b0;
      call_valid   <= 1'b0;
      call_ctr     <= '0;
      total_served <= '0;
    end else begin
      btn_low      <= ~button;
      reject       <= refuse;
      call_valid   <= dispatch;
      waiting      <= waiting_next;
      total_served <= served_next;
      if (accept) begin
        last_ticket <= next_ticket(last_ticket);
      end
      if (advance_serve) begin
        serve_ptr <= next_ticket(serve_ptr);
      end
      if (dispatch) begin
        call_ctr <= CALL_W'(idle_idx);
      end
    end
  end

  // One service counter per desk; only the chosen idle counter is started.
  for (genvar i = 0; i < NUM_CTR; i++) begin : g_ctr
    assign start[i] = dispatch && (idle_idx == IDX_W'(i));

    resp_counter #(
      .TICKET_W       (TICKET_W),
      .SERVICE_CYCLES (SERVICE_CYCLES)
    ) u_ctr (
      .clk       (clk),
      .rst       (rst),
      .start     (start[i]),
      .ticket_in (dispatch_ticket),
      .busy      (ctr_busy[i]),
      .ticket    (ctr_ticket[i*TICKET_W +: TICKET_W]),
      .done      (done[i])
    );
  end

endmodule

// File: tb/tb_resp_dispatch.sv
// Directed testbench for resp_dispatch.
// Three instances share clock and reset: the default build, a slow-service
// build (3 counters, long service) to fill the queue, and a 3-bit ticket
// build with one fast counter to exercise wrap-around and same-edge
// issue/dispatch.
module tb_resp_dispatch;

  logic clk;
  logic rst;

  // Default instance
  logic        button_m;
  logic [5:0]  lt_m;
  logic [4:0]  wt_m;
  logic        rj_m;
  logic [4:0]  busy_m;
  logic [29:0] tk_m;
  logic        cv_m;
  logic [2:0]  cc_m;
  logic [15:0] ts_m;

  // Slow-service instance
  logic        button_s;
  logic [5:0]  lt_s;
  logic [4:0]  wt_s;
  logic        rj_s;
  logic [2:0]  busy_s;
  logic [17:0] tk_s;
  logic        cv_s;
  logic [2:0]  cc_s;
  logic [15:0] ts_s;

  // 3-bit ticket instance
  logic        button_w;
  logic [2:0]  lt_w;
  logic [2:0]  wt_w;
  logic        rj_w;
  logic [0:0]  busy_w;
  logic [2:0]  tk_w;
  logic        cv_w;
  logic [2:0]  cc_w;
  logic [15:0] ts_w;

  int checks;
  int errors;

  resp_dispatch dut_m (
    .clk(clk), .rst(rst), .button(button_m),
`ifdef RESP_PRIORITY_EN
    .vip(1'b0),
`endif
    .last_ticket(lt_m), .waiting(wt_m), .reject(rj_m), .ctr_busy(busy_m),
    .ctr_ticket(tk_m), .call_valid(cv_m), .call_ctr(cc_m), .total_served(ts_m)
  );

  resp_dispatch #(.NUM_CTR(3), .SERVICE_CYCLES(200)) dut_s (
    .clk(clk), .rst(rst), .button(button_s),
`ifdef RESP_PRIORITY_EN
    .vip(1'b0),
`endif
    .last_ticket(lt_s), .waiting(wt_s), .reject(rj_s), .ctr_busy(busy_s),
    .ctr_ticket(tk_s), .call_valid(cv_s), .call_ctr(cc_s), .total_served(ts_s)
  );

  resp_dispatch #(.NUM_CTR(1), .TICKET_W(3), .QUEUE_DEPTH(4), .SERVICE_CYCLES(2)) dut_w (
    .clk(clk), .rst(rst), .button(button_w),
`ifdef RESP_PRIORITY_EN
    .vip(1'b0),
`endif
    .last_ticket(lt_w), .waiting(wt_w), .reject(rj_w), .ctr_busy(busy_w),
    .ctr_ticket(tk_w), .call_valid(cv_w), .call_ctr(cc_w), .total_served(ts_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    button_m = 1'b0;
    button_s = 1'b0;
    button_w = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    button_m = 1'b1;
    button_s = 1'b0;
    button_w = 1'b0;
    tick();
    tick();
    checks++; if (lt_m !== 6'd0) begin errors++; $display("[TB] FAIL reset_last_ticket: got %0d expected 0", lt_m); end
    checks++; if (wt_m !== 5'd0) begin errors++; $display("[TB] FAIL reset_waiting: got %0d expected 0", wt_m); end
    checks++; if (busy_m !== 5'd0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 00000", busy_m); end
    checks++; if (tk_m !== 30'd0) begin errors++; $display("[TB] FAIL reset_ctr_ticket: got %h expected 0", tk_m); end
    checks++; if (ts_m !== 16'd0 || cv_m !== 1'b0 || rj_m !== 1'b0) begin errors++; $display("[TB] FAIL reset_misc: got served=%0d call=%0d reject=%0d expected 0/0/0", ts_m, cv_m, rj_m); end
    rst = 1'b0;
    tick();
    checks++; if (lt_m !== 6'd0) begin errors++; $display("[TB] FAIL held_button_after_reset: got %0d expected 0", lt_m); end
    tick();
    checks++; if (lt_m !== 6'd0) begin errors++; $display("[TB] FAIL held_button_no_issue: got %0d expected 0", lt_m); end
    button_m = 1'b0;
    tick();
    button_m = 1'b1;
    tick();
    checks++; if (lt_m !== 6'd1) begin errors++; $display("[TB] FAIL first_press_after_reset: got %0d expected 1", lt_m); end
    button_m = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    button_m = 1'b1;
    tick();
    checks++; if (lt_m !== 6'd1 || wt_m !== 5'd1) begin errors++; $display("[TB] FAIL single_issue: got ticket=%0d waiting=%0d expected 1/1", lt_m, wt_m); end
    checks++; if (cv_m !== 1'b0) begin errors++; $display("[TB] FAIL single_no_same_edge_call: got %0d expected 0", cv_m); end
    button_m = 1'b0;
    tick();
    checks++; if (cv_m !== 1'b1 || cc_m !== 3'd0) begin errors++; $display("[TB] FAIL single_call: got valid=%0d ctr=%0d expected 1/0", cv_m, cc_m); end
    checks++; if (tk_m[5:0] !== 6'd1 || busy_m !== 5'b00001 || wt_m !== 5'd0) begin errors++; $display("[TB] FAIL single_dispatch_state: got ticket=%0d busy=%b waiting=%0d expected 1/00001/0", tk_m[5:0], busy_m, wt_m); end
    repeat (7) tick();
    checks++; if (busy_m !== 5'b00001 || ts_m !== 16'd0) begin errors++; $display("[TB] FAIL single_still_busy: got busy=%b served=%0d expected 00001/0", busy_m, ts_m); end
    tick();
    checks++; if (busy_m !== 5'b00000 || ts_m !== 16'd1) begin errors++; $display("[TB] FAIL single_complete: got busy=%b served=%0d expected 00000/1", busy_m, ts_m); end
    checks++; if (tk_m[5:0] !== 6'd1 || cv_m !== 1'b0) begin errors++; $display("[TB] FAIL single_ticket_retained: got ticket=%0d call=%0d expected 1/0", tk_m[5:0], cv_m); end
  endtask

  task automatic test_sequence();
    int got_ctr [7];
    int got_tk [7];
    int exp_ctr [7];
    int n;
    int idx;
    exp_ctr = '{0, 1, 2, 3, 4, 0, 1};
    n = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      button_m = ((i % 2) == 0) && (i < 14);
      tick();
      if (cv_m) begin
        idx = int'(cc_m);
        if (n < 7) begin
          got_ctr[n] = idx;
          got_tk[n]  = (idx < 5) ? int'(tk_m[idx*6 +: 6]) : -1;
        end
        n++;
      end
    end
    button_m = 1'b0;
    checks++; if (n != 7) begin errors++; $display("[TB] FAIL seq_dispatch_count: got %0d expected 7", n); end
    for (int k = 0; k < 7; k++) begin
      if (k < n) begin
        checks++; if (got_ctr[k] != exp_ctr[k] || got_tk[k] != k + 1) begin errors++; $display("[TB] FAIL seq_dispatch_%0d: got ctr=%0d ticket=%0d expected ctr=%0d ticket=%0d", k, got_ctr[k], got_tk[k], exp_ctr[k], k + 1); end
      end
    end
  endtask

  task automatic test_flood();
    int rej;
    int maxw;
    int prev;
    int bad_steps;
    rej = 0;
    maxw = 0;
    prev = 0;
    bad_steps = 0;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      button_s = ((i % 2) == 0) && (i < 48);
      tick();
      if (rj_s) rej++;
      if (int'(wt_s) > maxw) maxw = int'(wt_s);
      if (int'(lt_s) != prev) begin
        if (int'(lt_s) != prev + 1) bad_steps++;
        prev = int'(lt_s);
      end
    end
    button_s = 1'b0;
    checks++; if (rej != 5) begin errors++; $display("[TB] FAIL flood_reject_pulses: got %0d expected 5", rej); end
    checks++; if (maxw != 16 || wt_s !== 5'd16) begin errors++; $display("[TB] FAIL flood_waiting: got peak=%0d final=%0d expected 16/16", maxw, wt_s); end
    checks++; if (lt_s !== 6'd19 || bad_steps != 0) begin errors++; $display("[TB] FAIL flood_tickets: got last=%0d bad_steps=%0d expected 19/0", lt_s, bad_steps); end
    checks++; if (busy_s !== 3'b111 || ts_s !== 16'd0) begin errors++; $display("[TB] FAIL flood_counters: got busy=%b served=%0d expected 111/0", busy_s, ts_s); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      button_s = ((i % 2) == 0);
      tick();
    end
    button_s = 1'b0;
    checks++; if (wt_s !== 5'd4 || busy_s !== 3'b111 || cc_s !== 3'd2) begin errors++; $display("[TB] FAIL busy_setup: got waiting=%0d busy=%b ctr=%0d expected 4/111/2", wt_s, busy_s, cc_s); end
    rst = 1'b1;
    tick();
    checks++; if (lt_s !== 6'd0 || wt_s !== 5'd0 || busy_s !== 3'd0 || tk_s !== 18'd0) begin errors++; $display("[TB] FAIL busy_reset_state: got last=%0d waiting=%0d busy=%b tickets=%h expected all 0", lt_s, wt_s, busy_s, tk_s); end
    checks++; if (cc_s !== 3'd0 || cv_s !== 1'b0 || ts_s !== 16'd0) begin errors++; $display("[TB] FAIL busy_reset_outputs: got ctr=%0d call=%0d served=%0d expected 0/0/0", cc_s, cv_s, ts_s); end
    rst = 1'b0;
    tick();
    button_s = 1'b1;
    tick();
    checks++; if (lt_s !== 6'd1) begin errors++; $display("[TB] FAIL busy_reset_next_ticket: got %0d expected 1", lt_s); end
    button_s = 1'b0;
    tick();
    checks++; if (cv_s !== 1'b1 || cc_s !== 3'd0 || tk_s[5:0] !== 6'd1) begin errors++; $display("[TB] FAIL busy_reset_redispatch: got call=%0d ctr=%0d ticket=%0d expected 1/0/1", cv_s, cc_s, tk_s[5:0]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    button_w = 1'b1; tick();
    button_w = 1'b0; tick();
    button_w = 1'b1; tick();
    button_w = 1'b0; tick();
    button_w = 1'b1; tick();
    checks++; if (wt_w !== 3'd1 || lt_w !== 3'd3) begin errors++; $display("[TB] FAIL b2b_waiting: got waiting=%0d last=%0d expected 1/3", wt_w, lt_w); end
    checks++; if (cv_w !== 1'b1 || tk_w !== 3'd2 || busy_w !== 1'b1 || ts_w !== 16'd1) begin errors++; $display("[TB] FAIL b2b_dispatch: got call=%0d ticket=%0d busy=%0d served=%0d expected 1/2/1/1", cv_w, tk_w, busy_w, ts_w); end
    button_w = 1'b0;
    repeat (3) tick();
    checks++; if (cv_w !== 1'b1 || tk_w !== 3'd3 || wt_w !== 3'd0 || ts_w !== 16'd2) begin errors++; $display("[TB] FAIL b2b_followup: got call=%0d ticket=%0d waiting=%0d served=%0d expected 1/3/0/2", cv_w, tk_w, wt_w, ts_w); end
  endtask

  task automatic test_wrap();
    int exp_w [9];
    exp_w = '{1, 2, 3, 4, 5, 6, 7, 1, 2};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      button_w = 1'b1;
      tick();
      checks++; if (int'(lt_w) != exp_w[k]) begin errors++; $display("[TB] FAIL wrap_ticket_%0d: got %0d expected %0d", k, lt_w, exp_w[k]); end
      button_w = 1'b0;
      repeat (5) tick();
    end
    checks++; if (ts_w !== 16'd9 || wt_w !== 3'd0 || tk_w !== 3'd2) begin errors++; $display("[TB] FAIL wrap_served: got served=%0d waiting=%0d ticket=%0d expected 9/0/2", ts_w, wt_w, tk_w); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    button_m = 1'b0;
    button_s = 1'b0;
    button_w = 1'b0;
    test_reset();
    test_single();
    test_sequence();
    test_flood();
    test_reset_busy();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
